// File: rtl/sseg_hex_fmt_if.sv
// Formatter-to-host/driver bundle: display request in, segment word and handshake out.
interface sseg_hex_fmt_if;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        lzs;
  logic        load;
  logic        sseg_idle;
  logic [63:0] din;
  logic [7:0]  digit_en;
  logic        start;
  logic        busy;
  logic        done;

  modport master (
    output value, dp, blank, lzs, load, sseg_idle,
    input  din, digit_en, start, busy, done
  );

  modport slave (
    input  value, dp, blank, lzs, load, sseg_idle,
    output din, digit_en, start, busy, done
  );
endinterface

// File: rtl/sseg_hex_fmt.sv
// Hex-to-segment formatter and transfer sequencer for the seven-segment shift driver.
// Encodes one digit per cycle (7 down to 0), then runs the start/idle handshake.
module sseg_hex_fmt #(
  parameter int unsigned REFRESH_CYCLES = 0,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  sseg_hex_fmt_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENCODE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  localparam logic [23:0] TC_VAL = (REFRESH_CYCLES == 0) ? 24'd0 : 24'(REFRESH_CYCLES - 1);

  state_t      r_state;
  logic        r_pending;
  logic [23:0] r_timer;
  logic [31:0] r_value;
  logic [7:0]  r_dp;
  logic [7:0]  r_blank;
  logic        r_lzs;
  logic [2:0]  r_k;
  logic        r_leading;
  logic [63:0] r_din;
  logic [7:0]  r_en;

  logic [3:0]  w_nib;
  logic        w_dpk;
  logic        w_supp;
  logic        w_en;
  logic [7:0]  w_seg;
  logic [7:0]  w_raw;
  logic [7:0]  w_byte;
  logic        w_start;
  logic        w_tc;
  logic        w_idle_exit;

  always_comb begin
    w_nib  = r_value[{r_k, 2'b00} +: 4];
    w_dpk  = r_dp[r_k];
    w_seg  = 8'h00;
    case (w_nib)
      4'h0: w_seg = 8'hFC;
      4'h1: w_seg = 8'h60;
      4'h2: w_seg = 8'hDA;
      4'h3: w_seg = 8'hF2;
      4'h4: w_seg = 8'h66;
      4'h5: w_seg = 8'hB6;
      4'h6: w_seg = 8'hBE;
      4'h7: w_seg = 8'hE0;
      4'h8: w_seg = 8'hFE;
      4'h9: w_seg = 8'hF6;
      4'hA: w_seg = 8'hEE;
      4'hB: w_seg = 8'h3E;
      4'hC: w_seg = 8'h9C;
      4'hD: w_seg = 8'h7A;
      4'hE: w_seg = 8'h9E;
      4'hF: w_seg = 8'h8E;
      default: w_seg = 8'h00;
    endcase
    w_raw  = w_seg | {7'b0, w_dpk};
    w_supp = r_lzs & r_leading & (w_nib == 4'h0) & ~w_dpk & (r_k != 3'd0);
    w_en   = ~r_blank[r_k] & ~w_supp;
    w_byte = '0;
    if (w_en) begin
      w_byte = SEG_ACTIVE_LOW ? ~w_raw : w_raw;
    end
  end

  // start/done follow sseg_idle within the same cycle so start can never
  // coincide with a busy driver.
  assign w_start     = (r_state == S_ISSUE) & bus.sseg_idle;
  assign w_tc        = (REFRESH_CYCLES != 0) && (r_timer == TC_VAL) && !w_start;
  assign w_idle_exit = (r_state == S_IDLE) && (r_pending || bus.load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (REFRESH_CYCLES != 0) begin
      if (w_start || (r_timer == TC_VAL)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_value   <= '0;
      r_dp      <= '0;
      r_blank   <= '0;
      r_lzs     <= 1'b0;
      r_k       <= '0;
      r_leading <= 1'b0;
      r_din     <= '0;
      r_en      <= '0;
    end else begin
      if (w_idle_exit) begin
        r_pending <= 1'b0;
      end else if (bus.load || w_tc) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_idle_exit) begin
            r_value   <= bus.value;
            r_dp      <= bus.dp;
            r_blank   <= bus.blank;
            r_lzs     <= bus.lzs;
            r_k       <= 3'd7;
            r_leading <= 1'b1;
            r_state   <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          r_din[{r_k, 3'b000} +: 8] <= w_byte;
          r_en[r_k]                 <= w_en;
          if ((w_nib != 4'h0) || w_dpk) begin
            r_leading <= 1'b0;
          end
          if (r_k == 3'd0) begin
            r_state <= S_ISSUE;
          end else begin
            r_k <= r_k - 3'd1;
          end
        end
        S_ISSUE: begin
          if (bus.sseg_idle) begin
            r_state <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (!bus.sseg_idle) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.sseg_idle) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.din      = r_din;
  assign bus.digit_en = r_en;
  assign bus.start    = w_start;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_WAIT_DONE) & bus.sseg_idle;

endmodule

// File: tb/tb_sseg_hex_fmt.sv
// Scoreboard bench: dut_a (no refresh, active-high) takes loads; dut_b (refresh 1000,
// active-low, fixed blanked inputs) runs on refresh alone.
module tb_sseg_hex_fmt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sseg_hex_fmt_if ifa ();
  sseg_hex_fmt_if ifb ();

  sseg_hex_fmt #(.REFRESH_CYCLES(0), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  sseg_hex_fmt #(.REFRESH_CYCLES(1000), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Driver models: busy for 256 cycles after each start.
  int   drv_a = 0;
  int   drv_b = 0;
  logic stall_a = 1'b0;
  always @(posedge clk) begin
    if (ifa.start) drv_a <= 256;
    else if (drv_a > 0) drv_a <= drv_a - 1;
    if (ifb.start) drv_b <= 256;
    else if (drv_b > 0) drv_b <= drv_b - 1;
  end
  assign ifa.sseg_idle = (drv_a == 0) && !stall_a;
  assign ifb.sseg_idle = (drv_b == 0);

  localparam logic [7:0] SEG_TBL [0:15] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                            8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  // Digits above the most significant "significant" digit (nonzero or dp) are hidden under lzs.
  function automatic logic [71:0] model(input logic [31:0] v, input logic [7:0] d,
                                        input logic [7:0] b, input logic lz, input bit al);
    int          msd;
    logic [7:0]  en;
    logic [63:0] w;
    logic [3:0]  nib;
    logic [7:0]  sb;
    bit          vis;
    msd = 0;
    en  = '0;
    w   = '0;
    for (int k = 0; k < 8; k++) begin
      if ((((v >> (4 * k)) & 32'hF) != 0) || d[k]) msd = k;
    end
    for (int k = 0; k < 8; k++) begin
      nib = 4'((v >> (4 * k)) & 32'hF);
      vis = !b[k] && !(lz && (k > msd));
      sb  = SEG_TBL[nib] | {7'b0, d[k]};
      if (al) sb = ~sb;
      w[8 * k +: 8] = vis ? sb : 8'h00;
      en[k] = vis;
    end
    return {en, w};
  endfunction

  typedef struct packed {
    logic [63:0] din;
    logic [7:0]  en;
  } exp_t;
  exp_t q_a[$];
  int   n_push = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor A: every start pops one expected transfer.
  int starts_a = 0;
  int dones_a  = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (ifa.start) begin
        starts_a++;
        check("start_with_idle_a", 64'(ifa.sseg_idle), 64'd1);
        check("one_start_per_xfer_a", 64'(starts_a - dones_a), 64'd1);
        if (q_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_start_a: got start expected none (scoreboard empty)");
        end else begin
          e = q_a.pop_front();
          check("din_a", ifa.din, e.din);
          check("digit_en_a", 64'(ifa.digit_en), 64'(e.en));
        end
      end
      if (ifa.done) dones_a++;
    end
  end

  // Monitor B: refresh-only transfers of fixed content.
  int starts_b = 0;
  int dones_b  = 0;
  int last_start_b = 0;
  always @(negedge clk) begin
    logic [71:0] m;
    if (rst) begin
      if (ifb.start) begin
        m = model(32'h8888_8888, 8'h00, 8'hF0, 1'b0, 1'b1);
        starts_b++;
        check("start_with_idle_b", 64'(ifb.sseg_idle), 64'd1);
        check("one_start_per_xfer_b", 64'(starts_b - dones_b), 64'd1);
        check("refresh_interval_b", 64'((cyc - last_start_b >= 1000) && (cyc - last_start_b <= 1020)), 64'd1);
        check("din_b", ifb.din, m[63:0]);
        check("digit_en_b", 64'(ifb.digit_en), 64'(m[71:64]));
        last_start_b = cyc;
      end
      if (ifb.done) dones_b++;
    end
  end

  task automatic push_exp(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b, input logic lz);
    logic [71:0] m;
    m = model(v, d, b, lz, 1'b0);
    q_a.push_back('{din: m[63:0], en: m[71:64]});
    n_push++;
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b, input logic lz);
    @(negedge clk);
    ifa.value = v;
    ifa.dp    = d;
    ifa.blank = b;
    ifa.lzs   = lz;
    ifa.load  = 1'b1;
    @(negedge clk);
    ifa.load  = 1'b0;
  endtask

  task automatic wait_start_lat();
    int n;
    n = 1;
    while (!ifa.start && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", 64'(n), 64'd9);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifa.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (starts_a < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_timeout: got %0d starts expected %0d", starts_a, target);
    end
  endtask

  task automatic run_case(input logic [31:0] v, input logic [7:0] d, input logic [7:0] b, input logic lz);
    push_exp(v, d, b, lz);
    pulse_load(v, d, b, lz);
    wait_start_lat();
    wait_idle();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_din"}, ifa.din, 64'd0);
    check({tag, "_digit_en"}, 64'(ifa.digit_en), 64'd0);
    check({tag, "_start"}, 64'(ifa.start), 64'd0);
    check({tag, "_busy"}, 64'(ifa.busy), 64'd0);
    check({tag, "_done"}, 64'(ifa.done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [31:0] v;
    logic [7:0]  d, b;
    ifa.value = '0; ifa.dp = '0; ifa.blank = '0; ifa.lzs = 1'b0; ifa.load = 1'b0;
    ifb.value = 32'h8888_8888; ifb.dp = 8'h00; ifb.blank = 8'hF0; ifb.lzs = 1'b0; ifb.load = 1'b0;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_busy_b", 64'(ifb.busy), 64'd0);
    check("reset_din_b", ifb.din, 64'd0);
    rst = 1'b1;

    // Reset mid-ENCODE: outputs drop immediately, no start afterwards.
    pulse_load(32'h1234_5678, 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_start_b = cyc;
    repeat (20) @(negedge clk);
    check("no_start_after_reset", 64'(starts_a), 64'd0);

    run_case(32'h0123_89AF, 8'h04, 8'h00, 1'b0);
    run_case(32'h0000_0A05, 8'h00, 8'h00, 1'b1);
    run_case(32'h0000_0000, 8'h00, 8'h00, 1'b1);
    run_case(32'h0000_0A05, 8'h20, 8'h00, 1'b1);
    run_case(32'h8888_8888, 8'h00, 8'hF0, 1'b0);
    run_case(32'h0000_0000, 8'h01, 8'h01, 1'b1);

    // Driver busy on entry to ISSUE: start held back until idle returns.
    s = starts_a;
    stall_a = 1'b1;
    push_exp(32'hDEAD_BEEF, 8'h81, 8'h00, 1'b0);
    pulse_load(32'hDEAD_BEEF, 8'h81, 8'h00, 1'b0);
    repeat (58) @(negedge clk);
    check("stalled_no_start", 64'(starts_a), 64'(s));
    stall_a = 1'b0;
    wait_starts(s + 1);
    wait_idle();
    check("stall_single_start", 64'(starts_a), 64'(s + 1));

    // Loads during WAIT_DONE coalesce into one follow-up transfer with the last values.
    s = starts_a;
    push_exp(32'h0000_1111, 8'h00, 8'h00, 1'b1);
    pulse_load(32'h0000_1111, 8'h00, 8'h00, 1'b1);
    wait_starts(s + 1);
    repeat (20) @(negedge clk);
    pulse_load(32'h2222_2222, 8'h00, 8'h00, 1'b0);
    repeat (30) @(negedge clk);
    pulse_load(32'h3333_3333, 8'h0F, 8'h00, 1'b0);
    repeat (30) @(negedge clk);
    push_exp(32'h00C0_FFEE, 8'h10, 8'h02, 1'b1);
    pulse_load(32'h00C0_FFEE, 8'h10, 8'h02, 1'b1);
    wait_starts(s + 2);
    wait_idle();
    repeat (30) @(negedge clk);
    check("coalesced_start_count", 64'(starts_a), 64'(s + 2));

    for (int i = 0; i < 20; i++) begin
      v = $urandom >> $urandom_range(0, 32);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      run_case(v, d, b, 1'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 64'(q_a.size()), 64'd0);
    check("start_count_a", 64'(starts_a), 64'(n_push));
    check("done_count_a", 64'(dones_a), 64'(starts_a));
    check("refresh_count_b", 64'((starts_b >= (cyc - last_start_b > 0 ? 3 : 3)) && (starts_b <= cyc / 1000 + 1)), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
